// File: rtl/ir_scan_sequencer_pkg.sv
// State encoding and default parameter values shared by the IR scan sequencer
// and its settle timer.
package scan_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MOVE   = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_WRITE  = 3'd4,
        S_NEXT   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    localparam int          DEF_SETTLE_CYCLES = 2000000;
    localparam int          DEF_ANGLE_MIN     = 0;
    localparam int          DEF_ANGLE_MAX     = 180;
    localparam int          DEF_ANGLE_STEP    = 5;
    localparam logic [23:0] DEF_BASE_ADDR     = 24'h000400;

    // Smallest counter width that can hold SETTLE_CYCLES-1.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/ir_scan_sequencer_settle_timer.sv
// Loadable down-counter timing the servo settle interval; flags zero.
module settle_timer #(
    parameter int CNT_W = 21
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/ir_scan_sequencer.sv
// Sweeps the servo across the configured angle range, samples the IR ranger at
// each settled position and writes {angle, range} words through the memory arbiter.
module ir_scan_sequencer
    import scan_pkg::*;
#(
    parameter int          SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int          ANGLE_MIN     = DEF_ANGLE_MIN,
    parameter int          ANGLE_MAX     = DEF_ANGLE_MAX,
    parameter int          ANGLE_STEP    = DEF_ANGLE_STEP,
    parameter logic [23:0] BASE_ADDR     = DEF_BASE_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [7:0]  ir_in,
    output logic [15:0] angle,
    output logic        mem_req,
    input  logic        mem_grant,
    output logic [23:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    output logic        busy,
    output logic        done
);

    localparam int               CNT_W        = cnt_width(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [15:0]      ANGLE_MIN_W  = 16'(ANGLE_MIN);
    localparam logic [16:0]      ANGLE_MAX_W  = 17'(ANGLE_MAX);
    localparam logic [16:0]      ANGLE_STEP_W = 17'(ANGLE_STEP);

    state_t      r_state;
    logic [15:0] r_angle;
    logic [7:0]  r_idx;
    logic [7:0]  r_sample;
    logic        r_mem_req;
    logic        r_busy;
    logic        r_done;

    logic        w_load;
    logic        w_dec;
    logic        w_zero;
    logic [16:0] w_angle_next;

    assign w_load       = (r_state == S_MOVE);
    assign w_dec        = (r_state == S_SETTLE);
    assign w_angle_next = {1'b0, r_angle} + ANGLE_STEP_W;

    settle_timer #(
        .CNT_W(CNT_W)
    ) u_settle_timer (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_load     (w_load),
        .i_load_val (SETTLE_LOAD),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_angle   <= ANGLE_MIN_W;
            r_idx     <= '0;
            r_sample  <= '0;
            r_mem_req <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // A grant coinciding with stop has already committed through mem_we.
            if ((r_state != S_IDLE) && stop) begin
                r_state   <= S_IDLE;
                r_mem_req <= 1'b0;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_angle <= ANGLE_MIN_W;
                            r_idx   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= S_MOVE;
                        end
                    end
                    S_MOVE: begin
                        r_state <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (w_zero) begin
                            r_state <= S_SAMPLE;
                        end
                    end
                    S_SAMPLE: begin
                        r_sample  <= ir_in;
                        r_mem_req <= 1'b1;
                        r_state   <= S_WRITE;
                    end
                    S_WRITE: begin
                        if (mem_grant) begin
                            r_mem_req <= 1'b0;
                            r_state   <= S_NEXT;
                        end
                    end
                    S_NEXT: begin
                        if (w_angle_next > ANGLE_MAX_W) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_angle <= w_angle_next[15:0];
                            r_idx   <= r_idx + 8'd1;
                            r_state <= S_MOVE;
                        end
                    end
                    S_DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_mem_req <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Address and data derive from registers that only change outside WRITE.
    assign mem_addr  = BASE_ADDR + {16'd0, r_idx};
    assign mem_wdata = {r_angle[7:0], r_sample};
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_req & mem_grant;
    assign angle     = r_angle;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_ir_scan_sequencer.sv
// Self-checking bench for ir_scan_sequencer with a short settle time.
module tb_ir_scan_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        mem_grant = 1'b0;
    logic [7:0]  ir_in = 8'd0;
    logic [15:0] angle;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        busy;
    logic        done;

    logic        start7 = 1'b0;
    logic        stop7 = 1'b0;
    logic        grant7 = 1'b0;
    logic [7:0]  ir7 = 8'd0;
    logic [15:0] angle7;
    logic        req7;
    logic [23:0] addr7;
    logic [15:0] wdata7;
    logic        we7;
    logic        busy7;
    logic        done7;

    int          checks = 0;
    int          errors = 0;
    logic [39:0] act_q[$];
    logic [7:0]  irexp_q[$];
    int          done_cnt = 0;
    logic [7:0]  cur_ir = 8'h5a;

    ir_scan_sequencer #(.SETTLE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .ir_in(ir_in),
        .angle(angle), .mem_req(mem_req), .mem_grant(mem_grant), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .busy(busy), .done(done)
    );

    ir_scan_sequencer #(.SETTLE_CYCLES(4), .ANGLE_STEP(7)) dut7 (
        .clk(clk), .reset(reset), .start(start7), .stop(stop7), .ir_in(ir7),
        .angle(angle7), .mem_req(req7), .mem_grant(grant7), .mem_addr(addr7),
        .mem_wdata(wdata7), .mem_we(we7), .busy(busy7), .done(done7)
    );

    initial forever #5 clk = ~clk;

    // Observe at the falling edge; every committed write is logged with the
    // range value that was presented while the sensor was sampled.
    task automatic obs();
        @(negedge clk);
        if (mem_we) begin
            act_q.push_back({mem_addr, mem_wdata});
            irexp_q.push_back(cur_ir);
            cur_ir = 8'($urandom);
        end
        if (done) done_cnt++;
    endtask

    // While a write is pending the sensor input is scrambled: the word must
    // carry the value latched earlier, not the live input.
    task automatic adv();
        @(posedge clk);
        #1;
        ir_in = mem_req ? 8'($urandom) : cur_ir;
    endtask

    task automatic clear_log();
        act_q.delete();
        irexp_q.delete();
        done_cnt = 0;
    endtask

    // Reference: sample k is taken at angle k*step while that angle stays
    // within 0..180, written at 0x400+k.
    task automatic check_scan(input string name, input int step);
        int n = 0;
        for (int a = 0; a <= 180; a += step) n++;
        checks++;
        if (act_q.size() != n) begin
            errors++;
            $display("FAIL %s_count: got %0d writes expected %0d", name, act_q.size(), n);
        end
        for (int k = 0; k < n && k < act_q.size(); k++) begin
            logic [39:0] exp_w;
            exp_w = {24'h000400 + 24'(k), 8'(k * step), irexp_q[k]};
            checks++;
            if (act_q[k] !== exp_w) begin
                errors++;
                $display("FAIL %s_write%0d: got %h expected %h", name, k, act_q[k], exp_w);
            end
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL %s_done_pulses: got %0d expected 1", name, done_cnt);
        end
    endtask

    task automatic wait_req(input string name, output bit got);
        got = 1'b0;
        for (int c = 0; c < 200; c++) begin
            obs();
            if (mem_req) begin
                got = 1'b1;
                break;
            end
            adv();
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_req_timeout: got mem_req=0 expected 1", name);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mem_grant = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks += 7;
        if (angle !== 16'd0) begin errors++; $display("FAIL rst_angle: got %0d expected 0", angle); end
        if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", mem_req); end
        if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b expected 0", mem_we); end
        if (mem_addr !== 24'h000400) begin errors++; $display("FAIL rst_addr: got %h expected 000400", mem_addr); end
        if (mem_wdata !== 16'h0000) begin errors++; $display("FAIL rst_wdata: got %h expected 0000", mem_wdata); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
        adv();
        reset = 1'b0;
        mem_grant = 1'b0;
    endtask

    task automatic test_full_scan();
        bit seen = 1'b0;
        clear_log();
        mem_grant = 1'b1;
        start = 1'b1;
        adv();
        start = 1'b0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            obs();
            if (done) begin
                seen = 1'b1;
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL full_busy_at_done: got %b expected 1", busy); end
            end
            adv();
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL full_timeout: got done=0 expected 1"); end
        obs();
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_after: got %b expected 0", busy); end
        if (angle !== 16'd180) begin errors++; $display("FAIL full_angle_hold: got %0d expected 180", angle); end
        check_scan("full", 5);
        adv();
    endtask

    task automatic test_grant_delay();
        bit got;
        logic [15:0] exp_d;
        clear_log();
        mem_grant = 1'b0;
        start = 1'b1;
        adv();
        start = 1'b0;
        wait_req("gd", got);
        exp_d = {8'd0, cur_ir};
        for (int i = 0; i < 3; i++) begin
            if (i > 0) obs();
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 24'h000400 || mem_wdata !== exp_d) begin
                errors++;
                $display("FAIL gd_stall%0d: got req=%b we=%b addr=%h data=%h expected 1 0 000400 %h",
                         i, mem_req, mem_we, mem_addr, mem_wdata, exp_d);
            end
            adv();
        end
        mem_grant = 1'b1;
        obs();
        checks++;
        if (mem_we !== 1'b1) begin errors++; $display("FAIL gd_we: got %b expected 1", mem_we); end
        adv();
        mem_grant = 1'b0;
        obs();
        checks += 2;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL gd_req_drop: got %b expected 0", mem_req); end
        if (act_q.size() != 1) begin errors++; $display("FAIL gd_we_pulses: got %0d expected 1", act_q.size()); end
        adv();
        stop = 1'b1;
        obs();
        adv();
        stop = 1'b0;
        obs();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL gd_stop_busy: got %b expected 0", busy); end
        adv();
    endtask

    task automatic test_stop_settle();
        bit found = 1'b0;
        clear_log();
        mem_grant = 1'b1;
        start = 1'b1;
        adv();
        start = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            obs();
            if (busy && angle == 16'd45) begin
                found = 1'b1;
                break;
            end
            adv();
        end
        checks++;
        if (!found) begin errors++; $display("FAIL ss_reach45: got angle %0d expected 45", angle); end
        adv();
        stop = 1'b1;
        obs();
        adv();
        stop = 1'b0;
        obs();
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL ss_busy: got %b expected 0", busy); end
        if (angle !== 16'd45) begin errors++; $display("FAIL ss_angle: got %0d expected 45", angle); end
        for (int c = 0; c < 60; c++) begin
            adv();
            obs();
        end
        checks += 3;
        if (act_q.size() != 9) begin errors++; $display("FAIL ss_writes: got %0d expected 9", act_q.size()); end
        if (done_cnt != 0) begin errors++; $display("FAIL ss_done: got %0d expected 0", done_cnt); end
        if (angle !== 16'd45) begin errors++; $display("FAIL ss_angle_later: got %0d expected 45", angle); end
        adv();
    endtask

    task automatic test_stop_grant();
        bit got;
        clear_log();
        mem_grant = 1'b0;
        start = 1'b1;
        adv();
        start = 1'b0;
        wait_req("sg", got);
        adv();
        mem_grant = 1'b1;
        stop = 1'b1;
        obs();
        checks++;
        if (mem_we !== 1'b1) begin errors++; $display("FAIL sg_we: got %b expected 1", mem_we); end
        adv();
        mem_grant = 1'b0;
        stop = 1'b0;
        obs();
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL sg_busy: got %b expected 0", busy); end
        if (mem_req !== 1'b0) begin errors++; $display("FAIL sg_req: got %b expected 0", mem_req); end
        mem_grant = 1'b1;
        for (int c = 0; c < 30; c++) begin
            adv();
            obs();
        end
        mem_grant = 1'b0;
        checks += 2;
        if (act_q.size() != 1) begin errors++; $display("FAIL sg_writes: got %0d expected 1", act_q.size()); end
        if (done_cnt != 0) begin errors++; $display("FAIL sg_done: got %0d expected 0", done_cnt); end
        if (act_q.size() > 0) begin
            checks++;
            if (act_q[0][39:16] !== 24'h000400) begin
                errors++;
                $display("FAIL sg_addr: got %h expected 000400", act_q[0][39:16]);
            end
        end
        adv();
    endtask

    task automatic test_start_midscan();
        bit seen = 1'b0;
        clear_log();
        mem_grant = 1'b0;
        start = 1'b1;
        adv();
        start = 1'b0;
        for (int c = 0; c < 8000 && !seen; c++) begin
            obs();
            if (done) seen = 1'b1;
            adv();
            mem_grant = 1'($urandom_range(0, 1));
            start = (busy && ($urandom_range(0, 7) == 0)) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        mem_grant = 1'b0;
        checks++;
        if (!seen) begin errors++; $display("FAIL ms_timeout: got done=0 expected 1"); end
        for (int c = 0; c < 20; c++) begin
            obs();
            adv();
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ms_busy_end: got %b expected 0", busy); end
        check_scan("midstart", 5);
    endtask

    task automatic test_reset_mid_write();
        bit got;
        clear_log();
        mem_grant = 1'b0;
        start = 1'b1;
        adv();
        start = 1'b0;
        wait_req("rw", got);
        #1 reset = 1'b1;
        #1;
        checks += 3;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL rw_req_async: got %b expected 0", mem_req); end
        if (mem_we !== 1'b0) begin errors++; $display("FAIL rw_we_async: got %b expected 0", mem_we); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rw_busy_async: got %b expected 0", busy); end
        adv();
        reset = 1'b0;
        obs();
        checks += 2;
        if (angle !== 16'd0) begin errors++; $display("FAIL rw_angle: got %0d expected 0", angle); end
        if (mem_addr !== 24'h000400) begin errors++; $display("FAIL rw_addr: got %h expected 000400", mem_addr); end
        adv();
    endtask

    task automatic test_step7();
        bit seen = 1'b0;
        clear_log();
        grant7 = 1'b1;
        ir7 = 8'($urandom);
        start7 = 1'b1;
        @(posedge clk);
        #1;
        start7 = 1'b0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            @(negedge clk);
            if (we7) begin
                act_q.push_back({addr7, wdata7});
                irexp_q.push_back(ir7);
                ir7 = 8'($urandom);
            end
            if (done7) begin
                done_cnt++;
                seen = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL s7_timeout: got done=0 expected 1"); end
        @(negedge clk);
        checks += 2;
        if (busy7 !== 1'b0) begin errors++; $display("FAIL s7_busy: got %b expected 0", busy7); end
        if (angle7 !== 16'd175) begin errors++; $display("FAIL s7_last_angle: got %0d expected 175", angle7); end
        check_scan("step7", 7);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        test_reset();
        test_full_scan();
        test_grant_delay();
        test_stop_settle();
        test_stop_grant();
        test_start_midscan();
        test_reset_mid_write();
        test_step7();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
